control_sequencer: RTL and testbench

Next-generation control block for the ATMega32A emulator core. Latches an accepted instruction_id and steps it through an internal multi-cycle step counter, driving the datapath mux selects for each step. Also runs the interrupt-entry sequence, which pushes the PC and then loads the vector. Sits between the instruction decoder and the datapath muxes (SP, MM, PM, ALU, RF).

---
 rtl/ctrl_seq_pkg.sv | 77 +++++++
 rtl/ctrl_sel_decode.sv | 116 +++++++++++
 rtl/control_sequencer.sv | 154 +++++++++++++++
 tb/tb_control_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared constants for the control sequencer: FSM state codes, instruction ids
// and the select encodings for each datapath mux.
package ctrl_seq_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_EXEC     = 2'd1;
   localparam logic [1:0] ST_IRQ_PUSH = 2'd2;
   localparam logic [1:0] ST_IRQ_VEC  = 2'd3;

   localparam logic [7:0] ID_BRANCH_LO = 8'h04;
   localparam logic [7:0] ID_BRANCH_HI = 8'h08;
   localparam logic [7:0] ID_CLI       = 8'h0A;
   localparam logic [7:0] ID_ALU_IMM_A = 8'h0D;
   localparam logic [7:0] ID_INC       = 8'h0F;
   localparam logic [7:0] ID_MM_ARG2   = 8'h11;
   localparam logic [7:0] ID_DEC       = 8'h12;
   localparam logic [7:0] ID_LD        = 8'h19;
   localparam logic [7:0] ID_LDI       = 8'h20;
   localparam logic [7:0] ID_LPM       = 8'h22;
   localparam logic [7:0] ID_SP_LOAD   = 8'h29;
   localparam logic [7:0] ID_POP       = 8'h2A;
   localparam logic [7:0] ID_PUSH      = 8'h2B;
   localparam logic [7:0] ID_RCALL     = 8'h2C;
   localparam logic [7:0] ID_RET       = 8'h2D;
   localparam logic [7:0] ID_RETI      = 8'h2E;
   localparam logic [7:0] ID_RJMP      = 8'h2F;
   localparam logic [7:0] ID_SEI       = 8'h32;
   localparam logic [7:0] ID_ST        = 8'h38;
   localparam logic [7:0] ID_ALU_IMM_B = 8'h41;

   localparam logic [2:0] MM_ADDR_Y    = 3'd0;
   localparam logic [2:0] MM_ADDR_ARG2 = 3'd1;
   localparam logic [2:0] MM_ADDR_SP   = 3'd2;
   localparam logic [2:0] MM_ADDR_SP1  = 3'd3;
   localparam logic [2:0] MM_ADDR_SREG = 3'd4;

   localparam logic [1:0] MM_DATA_RD1  = 2'd0;
   localparam logic [1:0] MM_DATA_PC   = 2'd1;
   localparam logic [1:0] MM_DATA_SREG = 2'd3;

   localparam logic [1:0] PC_NEW_VEC   = 2'd0;
   localparam logic [1:0] PC_NEW_ARG1  = 2'd1;
   localparam logic [1:0] PC_NEW_ARG12 = 2'd2;
   localparam logic [1:0] PC_NEW_POP   = 2'd3;

   localparam logic [1:0] ALU2_RD2     = 2'd0;
   localparam logic [1:0] ALU2_ARG2    = 2'd1;
   localparam logic [1:0] ALU2_ONE     = 2'd2;

   localparam logic       ALU1_RD1     = 1'b0;
   localparam logic       ALU1_SPL     = 1'b1;

   localparam logic       RF_WA_ARG1   = 1'b0;
   localparam logic       RF_WA_MM     = 1'b1;

   localparam logic [2:0] RF_WD_ALU    = 3'd0;
   localparam logic [2:0] RF_WD_MM     = 3'd1;
   localparam logic [2:0] RF_WD_ARG2   = 3'd2;
   localparam logic [2:0] RF_WD_LPM    = 3'd3;
   localparam logic [2:0] RF_WD_MMQ    = 3'd4;

   typedef struct packed {
      logic [1:0] pc_byte_sel;
      logic       pc_load;
      logic       sp_we;
      logic       irq_ack;
      logic       sp_inl;
      logic [2:0] mm_addr;
      logic [1:0] mm_data;
      logic [1:0] pc_new;
      logic [1:0] alu_arg2;
      logic       alu_arg1;
      logic       rf_wa;
      logic [2:0] rf_wd;
   } sel_t;

endpackage

// File: rtl/ctrl_sel_decode.sv
// Combinational select decode: (phase, latched id, step) -> mux selects and
// raw strobes, plus the number of steps each instruction id occupies.
module ctrl_sel_decode
   import ctrl_seq_pkg::*;
#(
   parameter int ID_W     = 8,
   parameter int PC_BYTES = 2,
   parameter int STEP_W   = 3
) (
   input  logic [1:0]        phase,
   input  logic [ID_W-1:0]   id,
   input  logic [STEP_W-1:0] step,
   output sel_t              sel,
   output logic [STEP_W-1:0] n_steps
);

   logic in_pc_steps;
   assign in_pc_steps = (step < STEP_W'(PC_BYTES));

   // Step count per instruction id
   always_comb begin
      n_steps = STEP_W'(1);
      case (id)
         ID_LD, ID_ST, ID_PUSH, ID_POP: n_steps = STEP_W'(2);
         ID_RCALL, ID_RET, ID_RETI:     n_steps = STEP_W'(PC_BYTES + 1);
         default:                       n_steps = STEP_W'(1);
      endcase
   end

   // Select bundle for the current phase and step
   always_comb begin
      sel = '0;
      case (phase)
         ST_EXEC: begin
            case (id) inside
               ID_MM_ARG2: sel.mm_addr = MM_ADDR_ARG2;
               ID_SP_LOAD: begin
                  sel.mm_addr = MM_ADDR_ARG2;
                  sel.sp_inl  = 1'b1;
               end
               ID_CLI, ID_SEI: begin
                  sel.mm_addr = MM_ADDR_SREG;
                  sel.mm_data = MM_DATA_SREG;
               end
               [ID_BRANCH_LO:ID_BRANCH_HI]: begin
                  sel.pc_new  = PC_NEW_ARG1;
                  sel.pc_load = 1'b1;
               end
               ID_RJMP: begin
                  sel.pc_new  = PC_NEW_ARG12;
                  sel.pc_load = 1'b1;
               end
               ID_ALU_IMM_A, ID_ALU_IMM_B: sel.alu_arg2 = ALU2_ARG2;
               ID_INC, ID_DEC:             sel.alu_arg2 = ALU2_ONE;
               ID_LDI:                     sel.rf_wd    = RF_WD_ARG2;
               ID_LPM:                     sel.rf_wd    = RF_WD_LPM;
               ID_LD: begin
                  sel.rf_wa = RF_WA_MM;
                  sel.rf_wd = RF_WD_MMQ;
               end
               ID_ST: begin
                  sel.sp_inl = 1'b1;
                  sel.rf_wa  = RF_WA_MM;
                  sel.rf_wd  = RF_WD_MM;
               end
               ID_PUSH, ID_POP: begin
                  sel.mm_addr  = (id == ID_PUSH) ? MM_ADDR_SP : MM_ADDR_SP1;
                  sel.alu_arg1 = ALU1_SPL;
                  sel.alu_arg2 = ALU2_ONE;
                  sel.sp_we    = (step == STEP_W'(1));
               end
               ID_RCALL: begin
                  if (in_pc_steps) begin
                     sel.mm_addr     = MM_ADDR_SP;
                     sel.mm_data     = MM_DATA_PC;
                     sel.pc_byte_sel = step[1:0];
                     sel.alu_arg1    = ALU1_SPL;
                     sel.alu_arg2    = ALU2_ONE;
                     sel.sp_we       = 1'b1;
                  end else begin
                     sel.pc_new  = PC_NEW_ARG12;
                     sel.pc_load = 1'b1;
                  end
               end
               ID_RET, ID_RETI: begin
                  if (in_pc_steps) begin
                     sel.mm_addr  = MM_ADDR_SP1;
                     sel.alu_arg1 = ALU1_SPL;
                     sel.alu_arg2 = ALU2_ONE;
                     sel.sp_we    = 1'b1;
                  end else begin
                     sel.pc_new  = PC_NEW_POP;
                     sel.pc_load = 1'b1;
                  end
               end
               default: sel = '0;
            endcase
         end
         ST_IRQ_PUSH: begin
            sel.mm_addr     = MM_ADDR_SP;
            sel.mm_data     = MM_DATA_PC;
            sel.pc_byte_sel = step[1:0];
            sel.alu_arg1    = ALU1_SPL;
            sel.alu_arg2    = ALU2_ONE;
            sel.sp_we       = 1'b1;
         end
         ST_IRQ_VEC: begin
            sel.pc_new  = PC_NEW_VEC;
            sel.pc_load = 1'b1;
            sel.irq_ack = 1'b1;
         end
         default: sel = '0;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: accepts decoded instruction ids, steps them through a
// multi-cycle step counter and runs interrupt entry (push PC, load vector).
// Optional macro CTRL_SEQ_IFLAG_EN adds an internal global interrupt enable
// flag (SEI/CLI/RETI/IRQ entry); without it irq_req is always honoured.
//
// state       | meaning
// ST_IDLE     | waiting for an instruction or interrupt
// ST_EXEC     | stepping the latched instruction
// ST_IRQ_PUSH | pushing PC bytes, low byte first
// ST_IRQ_VEC  | loading the interrupt vector, irq_ack
module control_sequencer
   import ctrl_seq_pkg::*;
#(
   parameter int ID_W     = 8,
   parameter int PC_BYTES = 2,
   parameter int STEP_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [ID_W-1:0]   instruction_id,
   output logic              instr_ready,
   input  logic              irq_req,
   output logic              irq_ack,
   input  logic              stall,
   output logic              busy,
   output logic [STEP_W-1:0] step,
   output logic [1:0]        pc_byte_sel,
   output logic              pc_load,
   output logic              sp_we,
   output logic              SP_inL_sel,
   output logic [2:0]        MM_addr_sel,
   output logic [1:0]        MM_data_sel,
   output logic [1:0]        PM_PC_new_sel,
   output logic [1:0]        ALU_arg2_sel,
   output logic              ALU_arg1_sel,
   output logic              RF_WA_sel,
   output logic [2:0]        RF_WD_sel
);

   logic [1:0]        state;
   logic [STEP_W-1:0] step_q;
   logic [ID_W-1:0]   id_q;
   sel_t              sel;
   logic [STEP_W-1:0] n_steps;
   logic              last_step;
   logic              push_last;
   logic              irq_en;
   logic              take_window;
   logic              irq_take;
   logic              accept;
   logic              strobe_en;

   ctrl_sel_decode #(
      .ID_W     (ID_W),
      .PC_BYTES (PC_BYTES),
      .STEP_W   (STEP_W)
   ) u_decode (
      .phase   (state),
      .id      (id_q),
      .step    (step_q),
      .sel     (sel),
      .n_steps (n_steps)
   );

   assign last_step   = (state == ST_EXEC) && (step_q == n_steps - STEP_W'(1));
   assign push_last   = (step_q == STEP_W'(PC_BYTES - 1));
   // IDLE ignores stall: there is no in-flight work to freeze there.
   assign take_window = (state == ST_IDLE) || (last_step && !stall);
   assign irq_take    = take_window && irq_req && irq_en;
   assign instr_ready = take_window && !irq_take;
   assign accept      = instr_valid && instr_ready;

`ifdef CTRL_SEQ_IFLAG_EN
   logic iflag_q;
   assign irq_en = iflag_q;

   // Global interrupt enable: set by SEI/RETI, cleared by CLI and IRQ entry
   always_ff @(posedge clk) begin
      if (reset) begin
         iflag_q <= 1'b0;
      end else begin
         if (last_step && !stall) begin
            if (id_q == ID_SEI || id_q == ID_RETI) iflag_q <= 1'b1;
            else if (id_q == ID_CLI)               iflag_q <= 1'b0;
         end
         if (irq_take) iflag_q <= 1'b0;
      end
   end
`else
   assign irq_en = 1'b1;
`endif

   // Sequencing FSM and step counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         step_q <= '0;
         id_q   <= '0;
      end else if (irq_take) begin
         state  <= ST_IRQ_PUSH;
         step_q <= '0;
      end else if (accept) begin
         state  <= ST_EXEC;
         step_q <= '0;
         id_q   <= instruction_id;
      end else if (!stall) begin
         case (state)
            ST_EXEC: begin
               if (last_step) begin
                  state  <= ST_IDLE;
                  step_q <= '0;
               end else begin
                  step_q <= step_q + STEP_W'(1);
               end
            end
            ST_IRQ_PUSH: begin
               if (push_last) begin
                  state  <= ST_IRQ_VEC;
                  step_q <= '0;
               end else begin
                  step_q <= step_q + STEP_W'(1);
               end
            end
            ST_IRQ_VEC: begin
               state  <= ST_IDLE;
               step_q <= '0;
            end
            default: begin
               state  <= ST_IDLE;
               step_q <= '0;
            end
         endcase
      end
   end

   // Strobes act only on a cycle that really advances; a reset cycle aborts.
   assign strobe_en     = !stall && !reset;
   assign pc_load       = sel.pc_load && strobe_en;
   assign sp_we         = sel.sp_we && strobe_en;
   assign irq_ack       = sel.irq_ack && strobe_en;
   assign busy          = (state != ST_IDLE);
   assign step          = step_q;
   assign pc_byte_sel   = sel.pc_byte_sel;
   assign SP_inL_sel    = sel.sp_inl;
   assign MM_addr_sel   = sel.mm_addr;
   assign MM_data_sel   = sel.mm_data;
   assign PM_PC_new_sel = sel.pc_new;
   assign ALU_arg2_sel  = sel.alu_arg2;
   assign ALU_arg1_sel  = sel.alu_arg1;
   assign RF_WA_sel     = sel.rf_wa;
   assign RF_WD_sel     = sel.rf_wd;

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer (PC_BYTES=2) plus hand sequences on
// a PC_BYTES=3 instance. Extra rows exercise CTRL_SEQ_IFLAG_EN when defined.
module tb_control_sequencer;

   typedef struct packed {
      logic       rdy;
      logic       bsy;
      logic [2:0] stp;
      logic [1:0] pbs;
      logic       pcl;
      logic       spw;
      logic       ack;
      logic       inl;
      logic [2:0] mma;
      logic [1:0] mmd;
      logic [1:0] pcn;
      logic [1:0] a2;
      logic       a1;
      logic       wa;
      logic [2:0] wd;
   } out_t;

   typedef struct {
      string      nm;
      bit         rst;
      bit         v;
      logic [7:0] id;
      bit         irq;
      bit         st;
      out_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid;
   logic [7:0] instruction_id;
   logic       irq_req;
   logic       stall;

   logic       instr_ready, irq_ack, busy, pc_load, sp_we, SP_inL_sel, ALU_arg1_sel, RF_WA_sel;
   logic [2:0] step, MM_addr_sel, RF_WD_sel;
   logic [1:0] pc_byte_sel, MM_data_sel, PM_PC_new_sel, ALU_arg2_sel;

   logic       r3, ack3, bsy3, pcl3, spw3, inl3, a1_3, wa3;
   logic [2:0] stp3, mma3, wd3;
   logic [1:0] pbs3, mmd3, pcn3, a2_3;

   out_t act, act3;
   int   nchk = 0;
   int   nerr = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   control_sequencer #(.ID_W(8), .PC_BYTES(2), .STEP_W(3)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction_id(instruction_id),
      .instr_ready(instr_ready), .irq_req(irq_req), .irq_ack(irq_ack), .stall(stall),
      .busy(busy), .step(step), .pc_byte_sel(pc_byte_sel), .pc_load(pc_load), .sp_we(sp_we),
      .SP_inL_sel(SP_inL_sel), .MM_addr_sel(MM_addr_sel), .MM_data_sel(MM_data_sel),
      .PM_PC_new_sel(PM_PC_new_sel), .ALU_arg2_sel(ALU_arg2_sel), .ALU_arg1_sel(ALU_arg1_sel),
      .RF_WA_sel(RF_WA_sel), .RF_WD_sel(RF_WD_sel)
   );

   control_sequencer #(.ID_W(8), .PC_BYTES(3), .STEP_W(3)) dut3 (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction_id(instruction_id),
      .instr_ready(r3), .irq_req(irq_req), .irq_ack(ack3), .stall(stall),
      .busy(bsy3), .step(stp3), .pc_byte_sel(pbs3), .pc_load(pcl3), .sp_we(spw3),
      .SP_inL_sel(inl3), .MM_addr_sel(mma3), .MM_data_sel(mmd3),
      .PM_PC_new_sel(pcn3), .ALU_arg2_sel(a2_3), .ALU_arg1_sel(a1_3),
      .RF_WA_sel(wa3), .RF_WD_sel(wd3)
   );

   assign act  = {instr_ready, busy, step, pc_byte_sel, pc_load, sp_we, irq_ack, SP_inL_sel,
                  MM_addr_sel, MM_data_sel, PM_PC_new_sel, ALU_arg2_sel, ALU_arg1_sel,
                  RF_WA_sel, RF_WD_sel};
   assign act3 = {r3, bsy3, stp3, pbs3, pcl3, spw3, ack3, inl3, mma3, mmd3, pcn3, a2_3,
                  a1_3, wa3, wd3};

   function automatic out_t mk(int rdy, int bsy, int stp, int pbs, int pcl, int spw, int ack,
                               int inl, int mma, int mmd, int pcn, int a2, int a1, int wa,
                               int wd);
      out_t e;
      e.rdy = 1'(rdy); e.bsy = 1'(bsy); e.stp = 3'(stp); e.pbs = 2'(pbs);
      e.pcl = 1'(pcl); e.spw = 1'(spw); e.ack = 1'(ack); e.inl = 1'(inl);
      e.mma = 3'(mma); e.mmd = 2'(mmd); e.pcn = 2'(pcn); e.a2 = 2'(a2);
      e.a1  = 1'(a1);  e.wa  = 1'(wa);  e.wd  = 3'(wd);
      return e;
   endfunction

   // busy=1 row: rdy stp pbs pcl spw ack inl mma mmd pcn a2 a1 wa wd
   function automatic out_t x(int rdy, int stp, int pbs, int pcl, int spw, int ack, int inl,
                              int mma, int mmd, int pcn, int a2, int a1, int wa, int wd);
      return mk(rdy, 1, stp, pbs, pcl, spw, ack, inl, mma, mmd, pcn, a2, a1, wa, wd);
   endfunction

   function automatic out_t idl(int rdy);
      return mk(rdy, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic add(string nm, bit rst, bit v, int id, bit irq, bit st, out_t e);
      vec_t t;
      t.nm = nm; t.rst = rst; t.v = v; t.id = 8'(id); t.irq = irq; t.st = st; t.exp = e;
      vq.push_back(t);
   endtask

   task automatic chk(string nm, out_t a, out_t e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s actual=%h expected=%h", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cid[13];
      out_t csel[13];
      out_t prev;

      reset = 1'b1; instr_valid = 1'b0; instruction_id = 8'h00; irq_req = 1'b0; stall = 1'b0;
      tick();
      tick();

      add("reset_idle",    0, 0, 0, 0, 0, idl(1));
      // RCALL with back-to-back LDI on the last step
      add("rcall_acc",     0, 1, 'h2C, 0, 0, idl(1));
      add("rcall_s0",      0, 0, 0, 0, 0, x(0,0,0,0,1,0,0,2,1,0,2,1,0,0));
      add("rcall_s1",      0, 0, 0, 0, 0, x(0,1,1,0,1,0,0,2,1,0,2,1,0,0));
      add("rcall_s2_ldi",  0, 1, 'h20, 0, 0, x(1,2,0,1,0,0,0,0,0,2,0,0,0,0));
      add("ldi_s0",        0, 0, 0, 0, 0, x(1,0,0,0,0,0,0,0,0,0,0,0,0,2));
      add("idle_a",        0, 0, 0, 0, 0, idl(1));
      // reset mid-RCALL at step 1
      add("rcall2_acc",    0, 1, 'h2C, 0, 0, idl(1));
      add("rcall2_s0",     0, 0, 0, 0, 0, x(0,0,0,0,1,0,0,2,1,0,2,1,0,0));
      add("rcall2_s1_rst", 1, 0, 0, 0, 0, x(0,1,1,0,0,0,0,2,1,0,2,1,0,0));
      add("rst_abort",     0, 0, 0, 0, 0, idl(1));
      // LD then ST back to back
      add("ld_acc",        0, 1, 'h19, 0, 0, idl(1));
      add("ld_s0",         0, 0, 0, 0, 0, x(0,0,0,0,0,0,0,0,0,0,0,0,1,4));
      add("ld_s1_st",      0, 1, 'h38, 0, 0, x(1,1,0,0,0,0,0,0,0,0,0,0,1,4));
      add("st_s0",         0, 0, 0, 0, 0, x(0,0,0,0,0,0,1,0,0,0,0,0,1,1));
      add("st_s1",         0, 0, 0, 0, 0, x(1,1,0,0,0,0,1,0,0,0,0,0,1,1));
      // PUSH, then POP stalled three cycles on step 1
      add("push_acc",      0, 1, 'h2B, 0, 0, idl(1));
      add("push_s0",       0, 0, 0, 0, 0, x(0,0,0,0,0,0,0,2,0,0,2,1,0,0));
      add("push_s1",       0, 0, 0, 0, 0, x(1,1,0,0,1,0,0,2,0,0,2,1,0,0));
      add("pop_acc",       0, 1, 'h2A, 0, 0, idl(1));
      add("pop_s0",        0, 0, 0, 0, 0, x(0,0,0,0,0,0,0,3,0,0,2,1,0,0));
      for (int k = 0; k < 3; k++)
         add($sformatf("pop_stall%0d", k), 0, 0, 0, 0, 1, x(0,1,0,0,0,0,0,3,0,0,2,1,0,0));
      add("pop_s1_go",     0, 0, 0, 0, 0, x(1,1,0,0,1,0,0,3,0,0,2,1,0,0));
      add("pop_done",      0, 0, 0, 0, 0, idl(1));
      // RETI with PC_BYTES=2
      add("reti_acc",      0, 1, 'h2E, 0, 0, idl(1));
      add("reti_s0",       0, 0, 0, 0, 0, x(0,0,0,0,1,0,0,3,0,0,2,1,0,0));
      add("reti_s1",       0, 0, 0, 0, 0, x(0,1,0,0,1,0,0,3,0,0,2,1,0,0));
      add("reti_s2",       0, 0, 0, 0, 0, x(1,2,0,1,0,0,0,0,0,3,0,0,0,0));
      add("idle_b",        0, 0, 0, 0, 0, idl(1));

      // single-step chain: each row presents the next id, sees the previous one
      cid[0]  = 'h11; csel[0]  = x(1,0,0,0,0,0,0,1,0,0,0,0,0,0);
      cid[1]  = 'h29; csel[1]  = x(1,0,0,0,0,0,1,1,0,0,0,0,0,0);
      cid[2]  = 'h0A; csel[2]  = x(1,0,0,0,0,0,0,4,3,0,0,0,0,0);
      cid[3]  = 'h06; csel[3]  = x(1,0,0,1,0,0,0,0,0,1,0,0,0,0);
      cid[4]  = 'h2F; csel[4]  = x(1,0,0,1,0,0,0,0,0,2,0,0,0,0);
      cid[5]  = 'h0D; csel[5]  = x(1,0,0,0,0,0,0,0,0,0,1,0,0,0);
      cid[6]  = 'h41; csel[6]  = x(1,0,0,0,0,0,0,0,0,0,1,0,0,0);
      cid[7]  = 'h0F; csel[7]  = x(1,0,0,0,0,0,0,0,0,0,2,0,0,0);
      cid[8]  = 'h12; csel[8]  = x(1,0,0,0,0,0,0,0,0,0,2,0,0,0);
      cid[9]  = 'h22; csel[9]  = x(1,0,0,0,0,0,0,0,0,0,0,0,0,3);
      cid[10] = 'h00; csel[10] = x(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
      cid[11] = 'h77; csel[11] = x(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
      cid[12] = 'h08; csel[12] = x(1,0,0,1,0,0,0,0,0,1,0,0,0,0);
      prev = idl(1);
      for (int k = 0; k < 13; k++) begin
         add($sformatf("chain_%02h", cid[k]), 0, 1, cid[k], 0, 0, prev);
         prev = csel[k];
      end
      add("chain_last",    0, 0, 0, 0, 0, prev);
      add("idle_c",        0, 0, 0, 0, 0, idl(1));

      // IRQ beats instr_valid in IDLE (SEI first so the I-flag build also takes it)
      add("sei_acc",       0, 1, 'h32, 0, 0, idl(1));
      add("sei_s0",        0, 0, 0, 0, 0, x(1,0,0,0,0,0,0,4,3,0,0,0,0,0));
      add("irq_beats_v",   0, 1, 'h20, 1, 0, idl(0));
      add("irq_push0",     0, 1, 'h20, 0, 0, x(0,0,0,0,1,0,0,2,1,0,2,1,0,0));
      add("irq_push1",     0, 1, 'h20, 0, 0, x(0,1,1,0,1,0,0,2,1,0,2,1,0,0));
      add("irq_vec",       0, 1, 'h20, 0, 0, x(0,0,0,1,0,1,0,0,0,0,0,0,0,0));
      add("irq_then_ldi",  0, 1, 'h20, 0, 0, idl(1));
      add("ldi_post_irq",  0, 0, 0, 0, 0, x(1,0,0,0,0,0,0,0,0,0,0,0,0,2));
      add("idle_d",        0, 0, 0, 0, 0, idl(1));
      // IRQ taken on an EXEC last step
      add("sei2_acc",      0, 1, 'h32, 0, 0, idl(1));
      add("sei2_s0_ldi",   0, 1, 'h20, 0, 0, x(1,0,0,0,0,0,0,4,3,0,0,0,0,0));
      add("ldi_irq_last",  0, 1, 'h11, 1, 0, x(0,0,0,0,0,0,0,0,0,0,0,0,0,2));
      add("irq2_push0",    0, 0, 0, 0, 0, x(0,0,0,0,1,0,0,2,1,0,2,1,0,0));
      add("irq2_push1",    0, 0, 0, 0, 0, x(0,1,1,0,1,0,0,2,1,0,2,1,0,0));
      add("irq2_vec",      0, 0, 0, 0, 0, x(0,0,0,1,0,1,0,0,0,0,0,0,0,0));
      add("idle_e",        0, 0, 0, 0, 0, idl(1));
`ifdef CTRL_SEQ_IFLAG_EN
      add("if_rst",        1, 0, 0, 1, 0, idl(1));
      add("if_ign_rst",    0, 0, 0, 1, 0, idl(1));
      add("if_sei_acc",    0, 1, 'h32, 1, 0, idl(1));
      add("if_sei_s0",     0, 0, 0, 1, 0, x(1,0,0,0,0,0,0,4,3,0,0,0,0,0));
      add("if_taken",      0, 0, 0, 1, 0, idl(0));
      add("if_push0",      0, 0, 0, 1, 0, x(0,0,0,0,1,0,0,2,1,0,2,1,0,0));
      add("if_push1",      0, 0, 0, 1, 0, x(0,1,1,0,1,0,0,2,1,0,2,1,0,0));
      add("if_vec",        0, 0, 0, 1, 0, x(0,0,0,1,0,1,0,0,0,0,0,0,0,0));
      add("if_ign_entry",  0, 0, 0, 1, 0, idl(1));
      add("if_reti_acc",   0, 1, 'h2E, 1, 0, idl(1));
      add("if_reti_s0",    0, 0, 0, 1, 0, x(0,0,0,0,1,0,0,3,0,0,2,1,0,0));
      add("if_reti_s1",    0, 0, 0, 1, 0, x(0,1,0,0,1,0,0,3,0,0,2,1,0,0));
      add("if_reti_s2",    0, 0, 0, 1, 0, x(1,2,0,1,0,0,0,0,0,3,0,0,0,0));
      add("if_taken_reti", 0, 0, 0, 1, 0, idl(0));
      add("if2_push0",     0, 0, 0, 0, 0, x(0,0,0,0,1,0,0,2,1,0,2,1,0,0));
      add("if2_push1",     0, 0, 0, 0, 0, x(0,1,1,0,1,0,0,2,1,0,2,1,0,0));
      add("if2_vec",       0, 0, 0, 0, 0, x(0,0,0,1,0,1,0,0,0,0,0,0,0,0));
      add("if2_idle",      0, 0, 0, 0, 0, idl(1));
`endif

      foreach (vq[i]) begin
         reset          = vq[i].rst;
         instr_valid    = vq[i].v;
         instruction_id = vq[i].id;
         irq_req        = vq[i].irq;
         stall          = vq[i].st;
         #2;
         chk(vq[i].nm, act, vq[i].exp);
         tick();
      end

      // PC_BYTES=3 instance: RET pops three bytes, then loads the popped PC
      reset = 1'b1; instr_valid = 1'b0; irq_req = 1'b0; stall = 1'b0;
      tick();
      reset = 1'b0; instr_valid = 1'b1; instruction_id = 8'h2D;
      #2; chk("p3_ret_acc", act3, idl(1));
      tick();
      instr_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2; chk($sformatf("p3_ret_s%0d", k), act3, x(0,k,0,0,1,0,0,3,0,0,2,1,0,0));
         tick();
      end
      #2; chk("p3_ret_s3", act3, x(1,3,0,1,0,0,0,0,0,3,0,0,0,0));
      tick();
      #2; chk("p3_ret_idle", act3, idl(1));

      // PC_BYTES=3 instance: RCALL pushes bytes 0,1,2
      instr_valid = 1'b1; instruction_id = 8'h2C;
      #1;
      tick();
      instr_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2; chk($sformatf("p3_rcall_s%0d", k), act3, x(0,k,k,0,1,0,0,2,1,0,2,1,0,0));
         tick();
      end
      #2; chk("p3_rcall_s3", act3, x(1,3,0,1,0,0,0,0,0,2,0,0,0,0));
      tick();
      #2; chk("p3_rcall_idle", act3, idl(1));

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
